// File: rtl/isqrt_pipe_pkg.sv
// Shared widths, stage payload and the single digit-recurrence step
// used by the pipelined integer square root.
package isqrt_pipe_pkg;

   localparam int unsigned X_W    = 32;
   localparam int unsigned Y_W    = 16;
   localparam int unsigned REM_W  = 18;
   localparam int unsigned N_ITER = 16;

   typedef struct packed {
      logic             vld;
      logic [X_W-1:0]   radicand;
      logic [REM_W-1:0] rem;
      logic [Y_W-1:0]   root;
   } isqrt_stage_t;

   // One restoring iteration: consume the top two radicand bits, emit one root bit.
   function automatic isqrt_stage_t isqrt_iter(input isqrt_stage_t s);
      isqrt_stage_t     o;
      logic [REM_W-1:0] rem_sh;
      logic [REM_W-1:0] trial;
      o          = s;
      rem_sh     = {s.rem[REM_W-3:0], s.radicand[X_W-1 -: 2]};
      trial      = {s.root, 2'b01};
      o.radicand = {s.radicand[X_W-3:0], 2'b00};
      if (rem_sh >= trial) begin
         o.rem  = rem_sh - trial;
         o.root = {s.root[Y_W-2:0], 1'b1};
      end else begin
         o.rem  = rem_sh;
         o.root = {s.root[Y_W-2:0], 1'b0};
      end
      return o;
   endfunction

endpackage

// File: rtl/isqrt_pipe_stage.sv
// One pipeline stage: ITER_PER_STAGE chained iterations followed by a register.
// Only the valid bit is reset; the datapath loads on valid tokens only.
module isqrt_pipe_stage
   import isqrt_pipe_pkg::*;
#(
   parameter int unsigned ITER_PER_STAGE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  isqrt_stage_t d,
   output isqrt_stage_t q
);

   isqrt_stage_t     nxt;
   logic             vld_q;
   logic [X_W-1:0]   radicand_q;
   logic [REM_W-1:0] rem_q;
   logic [Y_W-1:0]   root_q;

   always_comb begin
      nxt = d;
      for (int unsigned i = 0; i < ITER_PER_STAGE; i++) begin
         nxt = isqrt_iter(nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= nxt.vld;
   end

   always_ff @(posedge clk) begin
      if (d.vld) begin
         radicand_q <= nxt.radicand;
         rem_q      <= nxt.rem;
         root_q     <= nxt.root;
      end
   end

   assign q = '{vld: vld_q, radicand: radicand_q, rem: rem_q, root: root_q};

endmodule

// File: rtl/isqrt_pipe_responder.sv
// Fully pipelined floor(sqrt(x)) responder: one radicand per clock,
// results in order after N_STAGES cycles, no backpressure.
module isqrt_pipe_responder
   import isqrt_pipe_pkg::*;
#(
   parameter int unsigned ITER_PER_STAGE = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           x_vld,
   input  logic [X_W-1:0] x,
   output logic           y_vld,
   output logic [Y_W-1:0] y,
   output logic           busy
);

   localparam int unsigned N_STAGES = N_ITER / ITER_PER_STAGE;

   if (!(ITER_PER_STAGE inside {1, 2, 4, 8, 16})) begin : g_bad_param
      $error("isqrt_pipe_responder: ITER_PER_STAGE must be 1, 2, 4, 8 or 16");
   end

   isqrt_stage_t pipe [N_STAGES+1];
   logic         unused_tail;

   assign pipe[0] = '{vld: x_vld, radicand: x, rem: '0, root: '0};

   for (genvar j = 0; j < int'(N_STAGES); j++) begin : g_stage
      isqrt_pipe_stage #(
         .ITER_PER_STAGE (ITER_PER_STAGE)
      ) u_stage (
         .clk (clk),
         .rst (rst),
         .d   (pipe[j]),
         .q   (pipe[j+1])
      );
   end

   // Busy reflects only tokens already inside the pipeline.
   always_comb begin
      busy = 1'b0;
      for (int j = 1; j <= int'(N_STAGES); j++) begin
         busy = busy | pipe[j].vld;
      end
   end

   assign y_vld       = pipe[N_STAGES].vld;
   assign y           = pipe[N_STAGES].root;
   assign unused_tail = ^{pipe[N_STAGES].radicand, pipe[N_STAGES].rem};

endmodule

// File: doc/isqrt_pipe_responder.md
Name: isqrt_pipe_responder

Overview:
- Fully pipelined 32-bit unsigned integer square root.
- It is the responder end of the isqrt_x_vld/isqrt_x -> isqrt_y_vld/isqrt_y interface driven by the formula FSMs.
- Accepts one radicand per clock with no backpressure. Returns floor(sqrt(x)) a fixed number of cycles later, in order.
- Sits in the *_top wrappers beside the FSM that drives it.

Parameters:
- ITER_PER_STAGE, 1, digit-recurrence iterations per pipeline stage. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- N_STAGES, 16/ITER_PER_STAGE, derived localparam, not overridable. Equals latency in cycles.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- x_vld  input  1  radicand valid; may be high on any cycle, including back-to-back.
- x  input  32  unsigned radicand; sampled when x_vld=1.
- y_vld  output  1  result valid; high exactly one cycle per accepted x.
- y  output  16  floor(sqrt(x)) of the matching radicand.
- busy  output  1  high while any pipeline stage holds a valid token.

Behaviour:
- Algorithm: restoring digit-by-digit square root, 16 iterations, k = 15 down to 0.
  - rem = (rem << 2) | x[2k+1:2k]; rem is 18 bits.
  - trial = (root << 2) | 1, computed at 18 bits.
  - If rem >= trial: rem = rem - trial, root = (root << 1) | 1.
  - Else: root = root << 1.
  - root is 16 bits. Both rem and root start at 0.
- Stage j applies iterations j*ITER_PER_STAGE .. (j+1)*ITER_PER_STAGE-1, combinationally chained, followed by one register.
  - Per-stage register fields: vld, remaining radicand bits (shifted left by 2*ITER_PER_STAGE per stage), rem, root.
- Latency: x presented with x_vld=1 in cycle t produces y_vld=1 with y = result in cycle t+N_STAGES.
- Throughput: one result per cycle. Bubbles (x_vld=0) propagate unchanged, so the output valid pattern is the input pattern delayed by N_STAGES.
- Ordering: strictly FIFO; no reordering and no merging.
- Valid chain: only the vld bits are reset. Datapath registers are not reset and load only when their incoming vld=1, to save power.
- Reset values: y_vld=0, busy=0. y is don't-care while y_vld=0 (drives the last-stage root register).
- Reset mid-operation: a cycle with rst=1 clears every vld bit at that edge, so all in-flight tokens are dropped.
  - y_vld=0 from the first cycle after the reset edge.
  - x_vld during a rst=1 cycle is ignored.
- busy = OR of all stage vld bits. Combinational from registers; does not include x_vld.
- Boundaries:
  - x=0 -> y=0.
  - x=0xFFFFFFFF -> y=0xFFFF.
  - Perfect squares are exact.
  - Values one below a perfect square round down.
- No internal overflow: rem never exceeds 2*root+1 and fits in 18 bits.
- The comparison rem >= trial is unsigned at 18 bits.

Decomposition:
- Package isqrt_pipe_pkg:
  - X_W=32, Y_W=16, REM_W=18, N_ITER=16.
  - typedef struct packed isqrt_stage_t {vld, radicand[X_W-1:0], rem[REM_W-1:0], root[Y_W-1:0]}.
  - function isqrt_iter(isqrt_stage_t) returning one iterated stage.
- Sub-module isqrt_pipe_stage:
  - Parameter ITER_PER_STAGE.
  - Input isqrt_stage_t; registered output isqrt_stage_t.
  - Instantiated N_STAGES times in a generate loop.
- Top module: vld/data plumbing plus busy.

Test Plan:
- x=0, x_vld one cycle, ITER_PER_STAGE=1 -> y_vld=1, y=0 exactly 16 cycles later; busy high for those 16 cycles, then low.
- Back-to-back x=16,17,24,25,0xFFFFFFFF -> five consecutive y_vld cycles with y=4,4,4,5,0xFFFF, first at t+16.
- Pattern x_vld=1,0,0,1,1 with x=1,9,100 -> y_vld=1,0,0,1,1 delayed 16 cycles, y=1,3,10.
- Formula usage: a=1, b=4, c=9 on three consecutive cycles -> y=1,2,3 consecutively; sum 6.
- Reset mid-flight: four tokens issued, rst=1 for one cycle at t+5 -> no y_vld ever appears for them; busy=0 at t+6; new x=49 at t+7 -> y=7 at t+23.
- Repeat tests 2 and 3 with ITER_PER_STAGE=4 -> identical values at latency 4. Random 10k x compared against a reference model floor(sqrt) for every legal ITER_PER_STAGE.
